// File: rtl/swt_evt_pkg.sv
// Shared types and the round-robin search used by switch_event_arbiter.
// The search helper is sized for the largest supported switch count (32).
package swt_evt_pkg;

    typedef enum logic {IDLE, OFFER} state_t;

    localparam int N_DEFAULT = 8;
    localparam int MAX_N     = 32;

    // Returns {found, index}: first set bit of pend after ptr, wrapping at n-1.
    function automatic logic [5:0] rr_pick(input logic [31:0] pend,
                                           input logic [4:0]  ptr,
                                           input int          n);
        logic       found;
        logic [4:0] idx;
        int         j;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= n && !found) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (pend[j[4:0]]) begin
                    found = 1'b1;
                    idx   = j[4:0];
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search: first set request after ptr,
// wrapping explicitly at N-1 so non-power-of-two counts work.
module rr_arbiter
    import swt_evt_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [MAX_N-1:0] req_ext;
    logic [5:0]       pick;

    assign req_ext = MAX_N'(req);
    assign pick    = rr_pick(req_ext, 5'(ptr), N);
    assign found   = pick[5];
    assign winner  = IDX_W'(pick[4:0]);

endmodule

// File: rtl/switch_event_arbiter.sv
// Turns debounced switch levels into queued edge events shared over one
// valid/ready channel. Define SWT_FALL_EVENT_EN to also report falling edges.
module switch_event_arbiter
    import swt_evt_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     de_swt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_level,
    output logic [N-1:0]     pend,
    output logic             ovf
);

    state_t           state;
    logic             init;
    logic [N-1:0]     prev;
    logic [N-1:0]     plevel;
    logic [N-1:0]     rise;
    logic [N-1:0]     grant;
    logic [N-1:0]     pend_nxt;
    logic [N-1:0]     plevel_nxt;
    logic             ovf_nxt;
    logic             found;
    logic             load;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr;

    // The init cycle only captures levels, so no edges are seen then.
    assign rise = init ? '0 : (de_swt & ~prev);

`ifdef SWT_FALL_EVENT_EN
    logic [N-1:0] fall;
    assign fall = init ? '0 : (~de_swt & prev);
`endif

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (pend),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // Searching the registered bitmap keeps same-cycle arrivals out of the pick.
    assign load  = found && (!evt_valid || evt_ready);
    assign grant = load ? (N'(1) << winner) : '0;

    always_comb begin
        pend_nxt   = pend;
        plevel_nxt = plevel;
        ovf_nxt    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) pend_nxt[i] = 1'b0;
`ifdef SWT_FALL_EVENT_EN
            if (rise[i] || fall[i]) begin
                if (pend[i] && !grant[i]) begin
                    pend_nxt[i] = 1'b0;
                end else begin
                    pend_nxt[i]   = 1'b1;
                    plevel_nxt[i] = rise[i];
                end
            end
`else
            if (rise[i]) begin
                if (pend[i] && !grant[i]) ovf_nxt = 1'b1;
                pend_nxt[i]   = 1'b1;
                plevel_nxt[i] = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init <= 1'b1;
            prev <= '0;
            pend <= '0;
            ovf  <= 1'b0;
        end else if (init) begin
            init <= 1'b0;
            prev <= de_swt;
            ovf  <= 1'b0;
        end else begin
            prev <= de_swt;
            pend <= pend_nxt;
            ovf  <= ovf_nxt;
        end
    end

    // Pending polarity is data only; a bit is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (!init) plevel <= plevel_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_level <= 1'b0;
            ptr       <= IDX_W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= OFFER;
                        evt_valid <= 1'b1;
                        evt_idx   <= winner;
                        evt_level <= plevel[winner];
                        ptr       <= winner;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        if (found) begin
                            evt_idx   <= winner;
                            evt_level <= plevel[winner];
                            ptr       <= winner;
                        end else begin
                            state     <= IDLE;
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
